// File: rtl/lectura_operandos.sv
`default_nettype none
// ============================================================================
//  Module   : lectura_operandos
//  Purpose  : Operand-capture front end for the multiplier. Synchronises and
//             debounces the multiply push-button, latches both switch banks
//             as one atomic pair, offers the pair over a valid/ready
//             handshake and drives per-operand status LEDs.
//  Revision : 1.0  initial parametrised release
// ============================================================================
module lectura_operandos #(
    parameter int ANCHO          = 4,
    parameter int CICLOS_ESTABLE = 4
) (
    input  logic             reloj,
    input  logic             reinicio,
    input  logic [ANCHO-1:0] operandoA,
    input  logic [ANCHO-1:0] operandoB,
    input  logic             realizarMultiplicacion,
    input  logic             multiplicadorListo,
    output logic             datosValidos,
    output logic [ANCHO-1:0] operandoARegistrado,
    output logic [ANCHO-1:0] operandoBRegistrado,
    output logic             operandoCero,
    output logic             ledOperandoA,
    output logic             ledOperandoB,
    output logic             ocupado
);

    // The counter never needs to exceed CICLOS_ESTABLE-2: on the edge where it
    // would reach CICLOS_ESTABLE-1 the new level is accepted instead.
    localparam int C_ANCHO_CNT = (CICLOS_ESTABLE > 2) ? $clog2(CICLOS_ESTABLE) : 1;
    localparam logic [C_ANCHO_CNT-1:0] C_CNT_ULTIMO = C_ANCHO_CNT'(CICLOS_ESTABLE - 2);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        CAPTURA = 2'd1,
        ENTREGA = 2'd2,
        BLOQUEO = 2'd3
    } estado_t;

    // Synchroniser flops
    logic             boton_meta_q, boton_s_q;
    logic [ANCHO-1:0] a_meta_q, a_s_q;
    logic [ANCHO-1:0] b_meta_q, b_s_q;

    // Debounce state
    logic                   estable_q,  estable_d;
    logic [C_ANCHO_CNT-1:0] contador_q, contador_d;

    // Control and captured data
    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] opA_q, opA_d;
    logic [ANCHO-1:0] opB_q, opB_d;
    logic             cero_q, cero_d;
    logic             ledA_q, ledA_d;
    logic             ledB_q, ledB_d;
    logic             valido_q, valido_d;
    logic             ocupado_q, ocupado_d;

    // Two-flop synchronisers for the button and both switch banks
    always_ff @(posedge reloj) begin
        if (!reinicio) begin
            boton_meta_q <= 1'b0;
            boton_s_q    <= 1'b0;
            a_meta_q     <= '0;
            a_s_q        <= '0;
            b_meta_q     <= '0;
            b_s_q        <= '0;
        end else begin
            boton_meta_q <= realizarMultiplicacion;
            boton_s_q    <= boton_meta_q;
            a_meta_q     <= operandoA;
            a_s_q        <= a_meta_q;
            b_meta_q     <= operandoB;
            b_s_q        <= b_meta_q;
        end
    end

    // Debounce next state: a new level must persist before it is accepted;
    // any return to the accepted level restarts the count.
    always_comb begin
        estable_d  = estable_q;
        contador_d = contador_q;
        if (boton_s_q == estable_q) begin
            contador_d = '0;
        end else if (contador_q == C_CNT_ULTIMO) begin
            estable_d  = boton_s_q;
            contador_d = '0;
        end else begin
            contador_d = contador_q + 1'b1;
        end
    end

    // Debounce registers
    always_ff @(posedge reloj) begin
        if (!reinicio) begin
            estable_q  <= 1'b0;
            contador_q <= '0;
        end else begin
            estable_q  <= estable_d;
            contador_q <= contador_d;
        end
    end

    // FSM next state plus captured-data and registered-output next values
    always_comb begin
        estado_d = estado_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        cero_d   = cero_q;
        ledA_d   = ledA_q;
        ledB_d   = ledB_q;
        unique case (estado_q)
            ESPERA: begin
                if (estable_q) estado_d = CAPTURA;
            end
            CAPTURA: begin
                opA_d    = a_s_q;
                opB_d    = b_s_q;
                cero_d   = (a_s_q == '0) || (b_s_q == '0);
                ledA_d   = 1'b1;
                ledB_d   = 1'b1;
                estado_d = ENTREGA;
            end
            ENTREGA: begin
                if (multiplicadorListo) estado_d = BLOQUEO;
            end
            BLOQUEO: begin
                // Wait for release so a held button cannot retrigger
                if (!estable_q) estado_d = ESPERA;
            end
            default: estado_d = ESPERA;
        endcase
        valido_d  = (estado_d == ENTREGA);
        ocupado_d = (estado_d != ESPERA);
    end

    // FSM state, captured pair and registered Moore outputs
    always_ff @(posedge reloj) begin
        if (!reinicio) begin
            estado_q  <= ESPERA;
            opA_q     <= '0;
            opB_q     <= '0;
            cero_q    <= 1'b0;
            ledA_q    <= 1'b0;
            ledB_q    <= 1'b0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            cero_q    <= cero_d;
            ledA_q    <= ledA_d;
            ledB_q    <= ledB_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign datosValidos        = valido_q;
    assign operandoARegistrado = opA_q;
    assign operandoBRegistrado = opB_q;
    assign operandoCero        = cero_q;
    assign ledOperandoA        = ledA_q;
    assign ledOperandoB        = ledB_q;
    assign ocupado             = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_lectura_operandos.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lectura_operandos
//  Purpose  : Directed self-checking bench for lectura_operandos
//             (ANCHO=4, CICLOS_ESTABLE=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lectura_operandos;

    localparam int ANCHO          = 4;
    localparam int CICLOS_ESTABLE = 4;
    localparam int LAT_PRESS      = CICLOS_ESTABLE + 3;   // 7 edges
    localparam int LAT_RELEASE    = CICLOS_ESTABLE + 2;   // ocupado low after 6 edges

    logic             reloj = 1'b0;
    logic             reinicio = 1'b0;
    logic [ANCHO-1:0] operandoA = '0;
    logic [ANCHO-1:0] operandoB = '0;
    logic             realizarMultiplicacion = 1'b0;
    logic             multiplicadorListo = 1'b0;
    logic             datosValidos;
    logic [ANCHO-1:0] operandoARegistrado;
    logic [ANCHO-1:0] operandoBRegistrado;
    logic             operandoCero;
    logic             ledOperandoA;
    logic             ledOperandoB;
    logic             ocupado;

    int n_pass  = 0;
    int n_total = 0;

    lectura_operandos #(
        .ANCHO          (ANCHO),
        .CICLOS_ESTABLE (CICLOS_ESTABLE)
    ) dut (
        .reloj                  (reloj),
        .reinicio               (reinicio),
        .operandoA              (operandoA),
        .operandoB              (operandoB),
        .realizarMultiplicacion (realizarMultiplicacion),
        .multiplicadorListo     (multiplicadorListo),
        .datosValidos           (datosValidos),
        .operandoARegistrado    (operandoARegistrado),
        .operandoBRegistrado    (operandoBRegistrado),
        .operandoCero           (operandoCero),
        .ledOperandoA           (ledOperandoA),
        .ledOperandoB           (ledOperandoB),
        .ocupado                (ocupado)
    );

    always #5 reloj = ~reloj;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later
    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    function automatic logic [31:0] todas_salidas();
        return {19'd0, datosValidos, operandoARegistrado, operandoBRegistrado,
                operandoCero, ledOperandoA, ledOperandoB, ocupado};
    endfunction

    task automatic esperar_valido(input string tag, input int limite);
        int n = 0;
        while (!datosValidos && n < limite) begin tick(); n++; end
        chequear(tag, {31'd0, datosValidos}, 32'd1);
    endtask

    task automatic esperar_reposo(input string tag, input int limite);
        int n = 0;
        while (ocupado && n < limite) begin tick(); n++; end
        chequear(tag, {31'd0, ocupado}, 32'd0);
    endtask

    initial begin
        int cuenta_dv;

        // 1. Reset values
        reinicio = 1'b0;
        repeat (3) tick();
        chequear("reset_in", todas_salidas(), 32'd0);
        reinicio = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chequear($sformatf("idle_%0d", i), todas_salidas(), 32'd0);
        end

        // 2. Clean press, ready already high: one valid cycle 7 edges later
        operandoA = 4'h9; operandoB = 4'h3; multiplicadorListo = 1'b1;
        repeat (3) tick();                 // let switches settle through sync
        realizarMultiplicacion = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chequear($sformatf("press_dv_e%0d", k), {31'd0, datosValidos}, {31'd0, (k == LAT_PRESS)});
            if (k == LAT_PRESS - 2) chequear("press_ocup_pre", {31'd0, ocupado}, 32'd0);
            if (k == LAT_PRESS - 1) chequear("press_ocup", {31'd0, ocupado}, 32'd1);
            if (k == LAT_PRESS) begin
                chequear("press_A", {28'd0, operandoARegistrado}, 32'h9);
                chequear("press_B", {28'd0, operandoBRegistrado}, 32'h3);
                chequear("press_cero", {31'd0, operandoCero}, 32'd0);
                chequear("press_leds", {30'd0, ledOperandoA, ledOperandoB}, 32'd3);
            end
        end
        // Release latency
        realizarMultiplicacion = 1'b0;
        for (int k = 1; k <= LAT_RELEASE; k++) begin
            tick();
            if (k == LAT_RELEASE - 1) chequear("rel_ocup_hi", {31'd0, ocupado}, 32'd1);
            if (k == LAT_RELEASE)     chequear("rel_ocup_lo", {31'd0, ocupado}, 32'd0);
        end
        chequear("rel_leds_kept", {30'd0, ledOperandoA, ledOperandoB}, 32'd3);

        // 3. Bounce rejection: 2-cycle pulses, then low
        for (int i = 0; i < 8; i++) begin
            realizarMultiplicacion = ((i / 2) % 2 == 0);
            tick();
            chequear($sformatf("bounce_%0d", i), {30'd0, ocupado, datosValidos}, 32'd0);
        end
        realizarMultiplicacion = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chequear($sformatf("bounce_tail_%0d", i), {30'd0, ocupado, datosValidos}, 32'd0);
        end

        // 4. Back-pressure: data held while ready is low
        multiplicadorListo = 1'b0;
        operandoA = 4'h9; operandoB = 4'h3;
        repeat (3) tick();
        realizarMultiplicacion = 1'b1;
        esperar_valido("bp_valid", 20);
        operandoA = 4'h5;
        for (int i = 0; i < 20; i++) begin
            tick();
            chequear($sformatf("bp_hold_%0d", i), {27'd0, datosValidos, operandoARegistrado}, {27'd0, 1'b1, 4'h9});
        end
        multiplicadorListo = 1'b1;
        tick();
        chequear("bp_drop_dv", {31'd0, datosValidos}, 32'd0);
        chequear("bp_A_kept", {28'd0, operandoARegistrado}, 32'h9);
        realizarMultiplicacion = 1'b0;
        esperar_reposo("bp_idle", 20);

        // 5. Held button gives exactly one capture; second press with B=0
        operandoA = 4'h7; operandoB = 4'h2;
        repeat (3) tick();
        realizarMultiplicacion = 1'b1;
        cuenta_dv = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (datosValidos) cuenta_dv++;
        end
        chequear("held_one_capture", cuenta_dv, 32'd1);
        realizarMultiplicacion = 1'b0;
        esperar_reposo("held_idle", 20);
        operandoB = 4'h0;
        repeat (3) tick();
        realizarMultiplicacion = 1'b1;
        esperar_valido("zero_valid", 20);
        chequear("zero_cero", {31'd0, operandoCero}, 32'd1);
        chequear("zero_A", {28'd0, operandoARegistrado}, 32'h7);
        chequear("zero_B", {28'd0, operandoBRegistrado}, 32'h0);
        realizarMultiplicacion = 1'b0;
        esperar_reposo("zero_idle", 20);

        // 6. Reset during ENTREGA, button still held afterwards
        multiplicadorListo = 1'b0;
        operandoA = 4'hC; operandoB = 4'h4;
        repeat (3) tick();
        realizarMultiplicacion = 1'b1;
        esperar_valido("rst_mid_valid", 20);
        reinicio = 1'b0;
        tick();
        chequear("rst_mid_outputs", todas_salidas(), 32'd0);
        reinicio = 1'b1;
        multiplicadorListo = 1'b1;
        for (int k = 1; k <= LAT_PRESS; k++) begin
            tick();
            if (k == LAT_PRESS - 1) chequear("rst_relatch_pre", {31'd0, datosValidos}, 32'd0);
            if (k == LAT_PRESS) begin
                chequear("rst_relatch_dv", {31'd0, datosValidos}, 32'd1);
                chequear("rst_relatch_A", {28'd0, operandoARegistrado}, 32'hC);
            end
        end
        realizarMultiplicacion = 1'b0;
        esperar_reposo("final_idle", 20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
